sitcpxg_rx_buffer: RTL and testbench

SITCPXG_RX_BUFFER -- requirements
Module: sitcpxg_rx_buffer

---
 rtl/sitcpxg_rx_buffer_if.sv | 31 +++
 rtl/sitcpxg_rx_buffer.sv | 159 +++++++++++++++
 tb/tb_sitcpxg_rx_buffer.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sitcpxg_rx_buffer_if.sv
// Port bundle between the SiTCPXG core, the receive buffer and its downstream consumer.
// The slave modport is the buffer's view; master is the view of whatever drives it.
interface sitcpxg_rx_buffer_if;
  logic [15:0] USER_RX_SIZE;
  logic        USER_RX_CLR_ENB;
  logic        USER_RX_CLR_REQ;
  logic [15:0] USER_RX_RADR;
  logic [15:0] USER_RX_WADR;
  logic [7:0]  USER_RX_WENB;
  logic [63:0] USER_RX_WDAT;
  logic        FLUSH;
  logic        FLUSH_DONE;
  logic [63:0] OUT_D;
  logic [3:0]  OUT_B;
  logic        OUT_VALID;
  logic        OUT_READY;

  modport slave (
    output USER_RX_SIZE, USER_RX_CLR_REQ, USER_RX_RADR, FLUSH_DONE,
           OUT_D, OUT_B, OUT_VALID,
    input  USER_RX_CLR_ENB, USER_RX_WADR, USER_RX_WENB, USER_RX_WDAT,
           FLUSH, OUT_READY
  );

  modport master (
    input  USER_RX_SIZE, USER_RX_CLR_REQ, USER_RX_RADR, FLUSH_DONE,
           OUT_D, OUT_B, OUT_VALID,
    output USER_RX_CLR_ENB, USER_RX_WADR, USER_RX_WENB, USER_RX_WDAT,
           FLUSH, OUT_READY
  );
endinterface

// File: rtl/sitcpxg_rx_buffer.sv
// SiTCPXG receive buffer: byte-addressed 64-bit RAM written by the core, drained as
// left-justified beats of 1..8 bytes through a valid/ready port with a flush handshake.
module sitcpxg_rx_buffer #(
  parameter int AW = 13
) (
  input logic               XGMII_CLOCK,
  input logic               RSTn,
  sitcpxg_rx_buffer_if.slave bus
);

  localparam int PW    = AW + 3;
  localparam int DEPTH = 1 << AW;

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_DONE} flush_state_e;

  // Reset asserts immediately and releases two edges later, in step with the clock.
  logic [1:0] rst_sync;
  logic       rst_n;

  always_ff @(posedge XGMII_CLOCK or negedge RSTn) begin
    if (!RSTn) rst_sync <= 2'b00;
    else       rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_n = rst_sync[1];

  flush_state_e state, state_nxt;
  logic         done;

  logic [PW-1:0] wq, rd, ca;
  logic [PW-1:0] avail;
  logic [2:0]    off;
  logic [3:0]    room, len_c;
  logic          issue;

  logic [63:0]   ram_q;
  logic          v1;
  logic [2:0]    off1;
  logic [3:0]    len1;
  logic [63:0]   push_d;

  logic          head_valid, skid_valid;
  logic [63:0]   head_d, skid_d;
  logic [3:0]    head_b, skid_b;
  logic          pop;
  logic [1:0]    fill;

  logic [63:0]   mem [DEPTH];
  logic          unused_wadr;

  // NOTE: the RAM is deliberately left out of reset; a reset term would stop it mapping onto block RAM.
  always_ff @(posedge XGMII_CLOCK) begin
    for (int i = 0; i < 8; i++) begin
      if (bus.USER_RX_WENB[i])
        mem[bus.USER_RX_WADR[PW-1:3]][8*i +: 8] <= bus.USER_RX_WDAT[8*i +: 8];
    end
    if (issue) ram_q <= mem[rd[PW-1:3]];
  end

  assign done  = (state == ST_DONE);
  assign avail = wq - rd;
  assign off   = rd[2:0];
  assign room  = 4'd8 - {1'b0, off};
  assign len_c = (avail < {{(PW-4){1'b0}}, room}) ? avail[3:0] : room;

  // Beats in flight plus beats held must never exceed the two output slots.
  assign pop   = head_valid && !done && bus.OUT_READY;
  assign fill  = 2'(head_valid) + 2'(skid_valid) + 2'(v1) - 2'(pop);
  assign issue = (avail != '0) && (fill <= 2'd1) && (state == ST_IDLE);

  assign push_d = (ram_q << {off1, 3'b000}) & ~(64'hFFFF_FFFF_FFFF_FFFF >> {len1, 3'b000});

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge XGMII_CLOCK or negedge rst_n) begin
    if (!rst_n) begin
      wq         <= '0;
      rd         <= '0;
      ca         <= '0;
      v1         <= 1'b0;
      off1       <= '0;
      len1       <= '0;
      head_valid <= 1'b0;
      head_d     <= '0;
      head_b     <= '0;
      skid_valid <= 1'b0;
      skid_d     <= '0;
      skid_b     <= '0;
    end else if (done) begin
      wq         <= '0;
      rd         <= '0;
      ca         <= '0;
      v1         <= 1'b0;
      head_valid <= 1'b0;
      head_d     <= '0;
      head_b     <= '0;
      skid_valid <= 1'b0;
    end else begin
      wq <= bus.USER_RX_WADR[PW-1:0];
      if (issue) rd <= rd + PW'(len_c);
      if (pop)   ca <= ca + PW'(head_b);

      v1 <= issue;
      if (issue) begin
        off1 <= off;
        len1 <= len_c;
      end

      if (!head_valid || pop) begin
        if (skid_valid) begin
          head_valid <= 1'b1;
          head_d     <= skid_d;
          head_b     <= skid_b;
          skid_valid <= v1;
          skid_d     <= push_d;
          skid_b     <= len1;
        end else if (v1) begin
          head_valid <= 1'b1;
          head_d     <= push_d;
          head_b     <= len1;
        end else begin
          head_valid <= 1'b0;
          head_d     <= '0;
          head_b     <= '0;
        end
      end else if (v1) begin
        skid_valid <= 1'b1;
        skid_d     <= push_d;
        skid_b     <= len1;
      end
    end
  end

  always_ff @(posedge XGMII_CLOCK or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // NOTE: the default assignment first keeps this block free of inferred latches.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (bus.FLUSH)           state_nxt = ST_REQ;
      ST_REQ:  if (bus.USER_RX_CLR_ENB) state_nxt = ST_DONE;
      ST_DONE:                          state_nxt = ST_IDLE;
      default:                          state_nxt = ST_IDLE;
    endcase
  end

  assign bus.USER_RX_SIZE    = 16'((1 << PW) - 16);
  assign bus.USER_RX_RADR    = 16'(ca);
  assign bus.USER_RX_CLR_REQ = (state == ST_REQ);
  assign bus.FLUSH_DONE      = done;
  assign bus.OUT_VALID       = head_valid && !done;
  assign bus.OUT_D           = head_d;
  assign bus.OUT_B           = head_b;

  assign unused_wadr = ^bus.USER_RX_WADR;

endmodule

// File: tb/tb_sitcpxg_rx_buffer.sv
// Directed bench for sitcpxg_rx_buffer (AW=9): expected beats are queued as data is
// written and compared as the buffer hands them over.
module tb_sitcpxg_rx_buffer;

  typedef struct {
    logic [63:0] d;
    logic [3:0]  b;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  bit   sb_on  = 1'b1;
  beat_t sb_q[$];

  sitcpxg_rx_buffer_if bus ();

  sitcpxg_rx_buffer #(.AW(9)) dut (
    .XGMII_CLOCK (clk),
    .RSTn        (rst_n),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [63:0] d, input logic [3:0] b);
    beat_t e;
    e.d = d;
    e.b = b;
    sb_q.push_back(e);
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (sb_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain_pending", 64'(sb_q.size()), 64'd0);
  endtask

  task automatic drive_idle();
    bus.USER_RX_CLR_ENB = 1'b0;
    bus.USER_RX_WENB    = 8'h00;
    bus.USER_RX_WDAT    = 64'h0;
    bus.FLUSH           = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive_idle();
    bus.USER_RX_WADR = 16'd0;
    bus.OUT_READY    = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    repeat (4) tick();
  endtask

  // Scoreboard side: every accepted beat must match the oldest queued expectation.
  always @(negedge clk) begin
    if (sb_on && bus.OUT_VALID === 1'b1 && bus.OUT_READY === 1'b1) begin
      checks++;
      assert (sb_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_beat got 0x%0h/%0d expected no beat", bus.OUT_D, bus.OUT_B);
      end
      if (sb_q.size() != 0) begin
        beat_t e;
        e = sb_q.pop_front();
        check("beat_data", bus.OUT_D, e.d);
        check("beat_bytes", 64'(bus.OUT_B), 64'(e.b));
      end
    end
  end

  initial begin
    logic [63:0] bp_d [4];
    int n;

    rst_n = 1'b0;
    drive_idle();
    bus.USER_RX_WADR = 16'd0;
    bus.OUT_READY    = 1'b0;
    tick();
    tick();
    check("rst_valid", 64'(bus.OUT_VALID), 64'd0);
    check("rst_d", bus.OUT_D, 64'd0);
    check("rst_b", 64'(bus.OUT_B), 64'd0);
    check("rst_radr", 64'(bus.USER_RX_RADR), 64'd0);
    check("rst_clr_req", 64'(bus.USER_RX_CLR_REQ), 64'd0);
    check("rst_flush_done", 64'(bus.FLUSH_DONE), 64'd0);
    check("rx_size", 64'(bus.USER_RX_SIZE), 64'd4080);
    rst_n = 1'b1;
    repeat (4) tick();

    // Aligned word, with exact latency from the address change.
    bus.OUT_READY = 1'b1;
    tick();
    bus.USER_RX_WADR = 16'd0;
    bus.USER_RX_WENB = 8'hFF;
    bus.USER_RX_WDAT = 64'h0011_2233_4455_6677;
    push(64'h0011_2233_4455_6677, 4'd8);
    tick();
    bus.USER_RX_WADR = 16'd8;
    bus.USER_RX_WENB = 8'h00;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("latency_valid_c%0d", k), 64'(bus.OUT_VALID), (k == 3) ? 64'd1 : 64'd0);
    end
    tick();
    check("aligned_radr", 64'(bus.USER_RX_RADR), 64'd8);
    wait_drain(20);

    // Partial words: three leading bytes, then two bytes at an odd offset.
    do_reset();
    bus.OUT_READY = 1'b1;
    bus.USER_RX_WADR = 16'd0;
    bus.USER_RX_WENB = 8'hE0;
    bus.USER_RX_WDAT = 64'hAABB_CC00_0000_0000;
    push(64'hAABB_CC00_0000_0000, 4'd3);
    tick();
    bus.USER_RX_WADR = 16'd3;
    bus.USER_RX_WENB = 8'h00;
    wait_drain(20);
    tick();
    bus.USER_RX_WADR = 16'd3;
    bus.USER_RX_WENB = 8'h18;
    bus.USER_RX_WDAT = 64'h0000_00DD_EE00_0000;
    push(64'hDDEE_0000_0000_0000, 4'd2);
    tick();
    bus.USER_RX_WADR = 16'd5;
    bus.USER_RX_WENB = 8'h00;
    wait_drain(20);
    tick();
    check("partial_radr", 64'(bus.USER_RX_RADR), 64'd5);

    // Backpressure: four words held, then released back to back.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      bp_d[i] = 64'hA5A5_5A5A_0F0F_F0F0 ^ {32'(i + 1), 32'(i * 7)};
      bus.USER_RX_WADR = 16'(8 * i);
      bus.USER_RX_WENB = 8'hFF;
      bus.USER_RX_WDAT = bp_d[i];
      push(bp_d[i], 4'd8);
      tick();
    end
    bus.USER_RX_WADR = 16'd32;
    bus.USER_RX_WENB = 8'h00;
    repeat (5) tick();
    check("bp_hold_d_early", bus.OUT_D, bp_d[0]);
    repeat (5) tick();
    check("bp_hold_valid", 64'(bus.OUT_VALID), 64'd1);
    check("bp_hold_d", bus.OUT_D, bp_d[0]);
    check("bp_hold_b", 64'(bus.OUT_B), 64'd8);
    check("bp_hold_radr", 64'(bus.USER_RX_RADR), 64'd0);
    bus.OUT_READY = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("bp_stream_c%0d", k), 64'(bus.OUT_VALID), 64'd1);
    end
    tick();
    check("bp_radr", 64'(bus.USER_RX_RADR), 64'd32);
    wait_drain(20);

    // Flush with beats pending and the consumed pointer already advanced.
    do_reset();
    bus.OUT_READY    = 1'b1;
    bus.USER_RX_WADR = 16'd0;
    bus.USER_RX_WENB = 8'hFF;
    bus.USER_RX_WDAT = 64'h1122_3344_5566_7788;
    push(64'h1122_3344_5566_7788, 4'd8);
    tick();
    bus.USER_RX_WADR = 16'd8;
    bus.USER_RX_WENB = 8'h00;
    wait_drain(20);
    tick();
    bus.OUT_READY    = 1'b0;
    bus.USER_RX_WENB = 8'hFF;
    bus.USER_RX_WDAT = 64'hDEAD_BEEF_0000_0001;
    tick();
    bus.USER_RX_WADR = 16'd16;
    bus.USER_RX_WDAT = 64'hDEAD_BEEF_0000_0002;
    tick();
    bus.USER_RX_WADR = 16'd24;
    bus.USER_RX_WENB = 8'h00;
    repeat (6) tick();
    check("flush_pre_radr", 64'(bus.USER_RX_RADR), 64'd8);
    check("flush_pre_valid", 64'(bus.OUT_VALID), 64'd1);
    bus.FLUSH = 1'b1;
    @(negedge clk);
    check("flush_idle_clr_req", 64'(bus.USER_RX_CLR_REQ), 64'd0);
    tick();
    bus.FLUSH = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("flush_clr_req_c%0d", k), 64'(bus.USER_RX_CLR_REQ), 64'd1);
      check($sformatf("flush_done_low_c%0d", k), 64'(bus.FLUSH_DONE), 64'd0);
      tick();
    end
    bus.USER_RX_CLR_ENB = 1'b1;
    @(negedge clk);
    check("flush_clr_req_c4", 64'(bus.USER_RX_CLR_REQ), 64'd1);
    tick();
    bus.USER_RX_CLR_ENB = 1'b0;
    bus.FLUSH        = 1'b1;
    bus.USER_RX_WADR = 16'd0;
    bus.USER_RX_WENB = 8'hFF;
    bus.USER_RX_WDAT = 64'h0F1E_2D3C_4B5A_6978;
    @(negedge clk);
    check("flush_done_pulse", 64'(bus.FLUSH_DONE), 64'd1);
    check("flush_done_valid", 64'(bus.OUT_VALID), 64'd0);
    check("flush_done_clr_req", 64'(bus.USER_RX_CLR_REQ), 64'd0);
    tick();
    bus.FLUSH        = 1'b0;
    bus.USER_RX_WADR = 16'd8;
    bus.USER_RX_WENB = 8'h00;
    bus.OUT_READY    = 1'b1;
    push(64'h0F1E_2D3C_4B5A_6978, 4'd8);
    @(negedge clk);
    check("flush_after_done", 64'(bus.FLUSH_DONE), 64'd0);
    check("flush_after_radr", 64'(bus.USER_RX_RADR), 64'd0);
    check("flush_after_valid", 64'(bus.OUT_VALID), 64'd0);
    check("flush_ignored_in_done", 64'(bus.USER_RX_CLR_REQ), 64'd0);
    wait_drain(20);
    tick();
    check("flush_post_radr", 64'(bus.USER_RX_RADR), 64'd8);

    // Pointer wrap at 4096 bytes: advance to 4090, then write 12 bytes.
    do_reset();
    sb_on = 1'b0;
    bus.OUT_READY    = 1'b1;
    bus.USER_RX_WADR = 16'd4090;
    n = 0;
    while (bus.USER_RX_RADR != 16'd4090 && n < 2000) begin
      tick();
      n++;
    end
    check("prewrap_radr", 64'(bus.USER_RX_RADR), 64'd4090);
    sb_on = 1'b1;
    bus.USER_RX_WENB = 8'h3F;
    bus.USER_RX_WDAT = 64'h0000_0102_0304_0506;
    push(64'h0102_0304_0506_0000, 4'd6);
    tick();
    bus.USER_RX_WADR = 16'd4096;
    bus.USER_RX_WENB = 8'hFC;
    bus.USER_RX_WDAT = 64'h0708_090A_0B0C_0000;
    push(64'h0708_090A_0B0C_0000, 4'd6);
    tick();
    bus.USER_RX_WADR = 16'd4102;
    bus.USER_RX_WENB = 8'h00;
    wait_drain(20);
    tick();
    check("wrap_radr", 64'(bus.USER_RX_RADR), 64'd6);

    // Asynchronous reset between clock edges while a beat is held.
    bus.OUT_READY    = 1'b0;
    bus.USER_RX_WENB = 8'hFF;
    bus.USER_RX_WDAT = 64'hCAFE_F00D_1234_5678;
    tick();
    bus.USER_RX_WADR = 16'd4110;
    bus.USER_RX_WENB = 8'h00;
    repeat (5) tick();
    check("arst_pre_valid", 64'(bus.OUT_VALID), 64'd1);
    check("arst_pre_radr", 64'(bus.USER_RX_RADR), 64'd6);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 64'(bus.OUT_VALID), 64'd0);
    check("arst_radr", 64'(bus.USER_RX_RADR), 64'd0);
    check("arst_d", bus.OUT_D, 64'd0);
    check("arst_b", 64'(bus.OUT_B), 64'd0);
    tick();
    check("sb_empty", 64'(sb_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
